// File: rtl/selen_wb_pkg.sv
// Shared types for the selen writeback controller: load size encodings,
// the per-load metadata record kept while a load is outstanding, and the
// architectural zero register.
package selen_wb_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Encoding 2'b11 is not a real size; the aligner treats it as a word.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } ld_size_e;

  typedef struct packed {
    logic [4:0] rd;
    ld_size_e   size;
    logic       uns;
    logic [1:0] off;
  } ld_entry_t;

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    return 32'd1 << rd;
  endfunction

endpackage

// File: rtl/wb_ctrl_if.sv
// Bus bundle between the pipeline and the writeback controller: ALU result,
// load issue and response handshakes, register-file write port and the
// outstanding-load busy mask. The controller sits on the slave modport.
interface wb_ctrl_if #(
  parameter int XLEN = 32
);

  logic            alu_vld;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            ld_issue_vld;
  logic [4:0]      ld_issue_rd;
  logic [1:0]      ld_issue_size;
  logic            ld_issue_uns;
  logic [1:0]      ld_issue_off;
  logic            ld_issue_rdy;

  logic            ld_resp_vld;
  logic [XLEN-1:0] ld_resp_data;
  logic            ld_resp_rdy;

  logic            rf_we;
  logic [4:0]      rf_adr;
  logic [XLEN-1:0] rf_data;

  logic [31:0]     busy_mask;

  modport master (
    output alu_vld, alu_rd, alu_data,
    output ld_issue_vld, ld_issue_rd, ld_issue_size, ld_issue_uns, ld_issue_off,
    input  ld_issue_rdy,
    output ld_resp_vld, ld_resp_data,
    input  ld_resp_rdy,
    input  rf_we, rf_adr, rf_data,
    input  busy_mask
  );

  modport slave (
    input  alu_vld, alu_rd, alu_data,
    input  ld_issue_vld, ld_issue_rd, ld_issue_size, ld_issue_uns, ld_issue_off,
    output ld_issue_rdy,
    input  ld_resp_vld, ld_resp_data,
    output ld_resp_rdy,
    output rf_we, rf_adr, rf_data,
    output busy_mask
  );

endinterface

// File: rtl/wb_load_align.sv
// Load data aligner: picks the addressed byte or halfword out of the raw
// memory word and sign- or zero-extends it to XLEN. Purely combinational.
module wb_load_align
  import selen_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_data,
  input  ld_size_e        i_size,
  input  logic            i_uns,
  input  logic [1:0]      i_off,
  output logic [XLEN-1:0] o_data
);

  logic [4:0]      w_shift;
  logic [XLEN-1:0] w_shifted;

  // Shift the addressed lane down to bit 0, then extend by size.
  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_shift = 5'd0;
    case (i_size)
      SZ_BYTE: w_shift = {i_off, 3'b000};
      SZ_HALF: w_shift = {i_off[1], 4'b0000};
      default: w_shift = 5'd0;
    endcase
    w_shifted = i_data >> w_shift;
    o_data    = w_shifted;
    case (i_size)
      SZ_BYTE: o_data = {{(XLEN-8){~i_uns & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_data = {{(XLEN-16){~i_uns & w_shifted[15]}}, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: sole writer of the register file port. Merges
// single-cycle ALU results with in-order load responses, aligns load data,
// and exposes the destinations of outstanding loads as a busy mask.
// Optional feature: define SELEN_WB_ERR_EN to add the sticky err output
// flagging responses that arrive with no load outstanding.
module wb_ctrl
  import selen_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic     clk,
  input  logic     reset,
  wb_ctrl_if.slave bus
`ifdef SELEN_WB_ERR_EN
  ,
  output logic     err
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  ld_entry_t        r_q [DEPTH];
  logic [DEPTH-1:0] r_q_vld;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             r_hold_full;
  logic [4:0]       r_hold_rd;
  logic [XLEN-1:0]  r_hold_data;

  logic             r_rf_we;
  logic [4:0]       r_rf_adr;
  logic [XLEN-1:0]  r_rf_data;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_resp_acc;
  logic             w_pop;
  ld_entry_t        w_new;
  ld_entry_t        w_head;
  logic [XLEN-1:0]  w_aligned;
  logic [31:0]      w_busy;

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  // A full queue refuses issue even when the head pops this same cycle.
  assign w_push     = bus.ld_issue_vld && !w_full;
  assign w_resp_acc = bus.ld_resp_vld && !r_hold_full;
  // A response with nothing outstanding is accepted but matches no load.
  assign w_pop      = w_resp_acc && !w_empty;

  assign w_new.rd   = bus.ld_issue_rd;
  assign w_new.size = ld_size_e'(bus.ld_issue_size);
  assign w_new.uns  = bus.ld_issue_uns;
  assign w_new.off  = bus.ld_issue_off;
  assign w_head     = r_q[r_rd_ptr];

  wb_load_align #(.XLEN(XLEN)) u_align (
    .i_data (bus.ld_resp_data),
    .i_size (w_head.size),
    .i_uns  (w_head.uns),
    .i_off  (w_head.off),
    .o_data (w_aligned)
  );

  // Store the metadata of each issued load at the write pointer.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  // NOTE: payload slots carry no reset; r_q_vld alone says which slots hold a live load.
  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wr_ptr] <= w_new;
  end

  // Queue pointers, occupancy count and per-slot valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_q_vld  <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr          <= r_rd_ptr + PW'(1);
        r_q_vld[r_rd_ptr] <= 1'b0;
      end
      if (w_push) begin
        r_wr_ptr          <= r_wr_ptr + PW'(1);
        r_q_vld[r_wr_ptr] <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Register-file write arbitration: ALU first, then the parked load, then a fresh response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rf_we     <= 1'b0;
      r_rf_adr    <= '0;
      r_rf_data   <= '0;
      r_hold_full <= 1'b0;
      r_hold_rd   <= '0;
      r_hold_data <= '0;
    end else if (bus.alu_vld) begin
      r_rf_we <= (bus.alu_rd != REG_ZERO);
      if (bus.alu_rd != REG_ZERO) begin
        r_rf_adr  <= bus.alu_rd;
        r_rf_data <= bus.alu_data;
      end
      // A colliding response to x0 has nothing to write, so it is not parked.
      if (w_pop && (w_head.rd != REG_ZERO)) begin
        r_hold_full <= 1'b1;
        r_hold_rd   <= w_head.rd;
        r_hold_data <= w_aligned;
      end
    end else if (r_hold_full) begin
      r_rf_we     <= 1'b1;
      r_rf_adr    <= r_hold_rd;
      r_rf_data   <= r_hold_data;
      r_hold_full <= 1'b0;
    end else if (w_pop && (w_head.rd != REG_ZERO)) begin
      r_rf_we   <= 1'b1;
      r_rf_adr  <= w_head.rd;
      r_rf_data <= w_aligned;
    end else begin
      r_rf_we <= 1'b0;
    end
  end

`ifdef SELEN_WB_ERR_EN
  logic w_orphan;
  logic r_err;

  assign w_orphan = w_resp_acc && w_empty;

  // Sticky protocol-violation flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)         r_err <= 1'b0;
    else if (w_orphan) r_err <= 1'b1;
  end

  assign err = r_err;
`endif

  // Busy mask from registered queue and hold state only; x0 is never busy.
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_q_vld[i]) w_busy = w_busy | rd_onehot(r_q[i].rd);
    end
    if (r_hold_full) w_busy = w_busy | rd_onehot(r_hold_rd);
    w_busy[0] = 1'b0;
  end

  assign bus.ld_issue_rdy = !w_full;
  assign bus.ld_resp_rdy  = !r_hold_full;
  assign bus.rf_we        = r_rf_we;
  assign bus.rf_adr       = r_rf_adr;
  assign bus.rf_data      = r_rf_data;
  assign bus.busy_mask    = w_busy;

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl. Directed stimulus pushes the expected
// register-file writes into a scoreboard queue; an independent monitor pops
// and compares on every rf_we. Handshake and busy-mask values are checked
// directly against hand-computed constants.
module tb_wb_ctrl;

  logic clk;
  logic reset;

  wb_ctrl_if #(.XLEN(32)) bus ();

`ifdef SELEN_WB_ERR_EN
  logic err;
`endif

  wb_ctrl #(.DEPTH(4), .XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SELEN_WB_ERR_EN
    ,
    .err   (err)
`endif
  );

  typedef struct {
    logic [4:0]  adr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input logic [4:0] adr, input logic [31:0] data);
    wr_t e;
    e.adr  = adr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] size, input logic uns,
                       input logic [1:0] off);
    bus.ld_issue_vld  = 1'b1;
    bus.ld_issue_rd   = rd;
    bus.ld_issue_size = size;
    bus.ld_issue_uns  = uns;
    bus.ld_issue_off  = off;
  endtask

  task automatic resp(input logic [31:0] data);
    bus.ld_resp_vld  = 1'b1;
    bus.ld_resp_data = data;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] data);
    bus.alu_vld  = 1'b1;
    bus.alu_rd   = rd;
    bus.alu_data = data;
  endtask

  task automatic idle();
    bus.alu_vld      = 1'b0;
    bus.ld_issue_vld = 1'b0;
    bus.ld_resp_vld  = 1'b0;
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.rf_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got x%0d <= 0x%0h, expected no write",
                   bus.rf_adr, bus.rf_data);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("wb_x%0d", e.adr), {27'd0, bus.rf_adr, bus.rf_data},
                {27'd0, e.adr, e.data});
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.alu_rd        = '0;
    bus.alu_data      = '0;
    bus.ld_issue_rd   = '0;
    bus.ld_issue_size = '0;
    bus.ld_issue_uns  = 1'b0;
    bus.ld_issue_off  = '0;
    bus.ld_resp_data  = '0;
    idle();
    reset = 1'b1;
    repeat (3) step();

    // Reset values.
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_rf_adr", bus.rf_adr, 0);
    check("rst_rf_data", bus.rf_data, 0);
    check("rst_busy", bus.busy_mask, 0);
    check("rst_issue_rdy", bus.ld_issue_rdy, 1);
    check("rst_resp_rdy", bus.ld_resp_rdy, 1);
`ifdef SELEN_WB_ERR_EN
    check("rst_err", err, 0);
`endif
    reset = 1'b0;
    step();

    // ALU write visible for exactly one cycle.
    alu(5'd5, 32'hDEAD_BEEF);
    exp_wr(5'd5, 32'hDEAD_BEEF);
    step();
    check("alu_we_n1", bus.rf_we, 1);
    idle();
    step();
    check("alu_we_n2", bus.rf_we, 0);

    // Signed byte, off=3; busy bit lifetime.
    issue(5'd7, 2'b00, 1'b0, 2'd3);
    step();
    idle();
    check("busy7_set", bus.busy_mask, 32'd1 << 7);
    step();
    check("busy7_hold", bus.busy_mask, 32'd1 << 7);
    resp(32'h80FF_1234);
    exp_wr(5'd7, 32'hFFFF_FF80);
    step();
    idle();
    check("busy7_clr_at_we", {bus.rf_we, bus.busy_mask}, {1'b1, 32'd0});

    // Unsigned byte, off=3.
    issue(5'd7, 2'b00, 1'b1, 2'd3);
    step();
    idle();
    resp(32'h80FF_1234);
    exp_wr(5'd7, 32'h0000_0080);
    step();
    idle();

    // Collision: ALU x3 and load x9 in the same cycle.
    issue(5'd9, 2'b10, 1'b0, 2'd0);
    step();
    idle();
    alu(5'd3, 32'h1111_1111);
    resp(32'h1234_5678);
    exp_wr(5'd3, 32'h1111_1111);
    exp_wr(5'd9, 32'h1234_5678);
    step();
    idle();
    check("coll_resp_rdy_n1", bus.ld_resp_rdy, 0);
    check("coll_busy_n1", bus.busy_mask, 32'd1 << 9);
    step();
    check("coll_busy_n2", bus.busy_mask, 0);
    check("coll_resp_rdy_n2", bus.ld_resp_rdy, 1);

    // Collision held off by three consecutive ALU writes (unsigned half, off=0).
    issue(5'd10, 2'b01, 1'b1, 2'd0);
    step();
    idle();
    alu(5'd4, 32'hA1A1_A1A1);
    resp(32'h0000_8001);
    exp_wr(5'd4, 32'hA1A1_A1A1);
    step();
    bus.ld_resp_vld = 1'b0;
    alu(5'd4, 32'hA2A2_A2A2);
    exp_wr(5'd4, 32'hA2A2_A2A2);
    check("stall_resp_rdy_a", bus.ld_resp_rdy, 0);
    step();
    alu(5'd4, 32'hA3A3_A3A3);
    exp_wr(5'd4, 32'hA3A3_A3A3);
    check("stall_resp_rdy_b", bus.ld_resp_rdy, 0);
    step();
    idle();
    exp_wr(5'd10, 32'h0000_8001);
    check("stall_busy10", bus.busy_mask, 32'd1 << 10);
    step();
    check("stall_drained", {bus.ld_resp_rdy, bus.busy_mask}, {1'b1, 32'd0});

    // Fill the queue; push-while-full is refused even while popping.
    issue(5'd11, 2'b00, 1'b1, 2'd1);
    step();
    issue(5'd12, 2'b01, 1'b0, 2'd2);
    step();
    issue(5'd13, 2'b11, 1'b0, 2'd1);
    step();
    issue(5'd14, 2'b01, 1'b0, 2'd3);
    step();
    issue(5'd15, 2'b10, 1'b0, 2'd0);
    check("full_issue_rdy", bus.ld_issue_rdy, 0);
    check("full_busy", bus.busy_mask, 32'h0000_7800);
    resp(32'h0000_AB00);
    exp_wr(5'd11, 32'h0000_00AB);
    step();
    bus.ld_issue_vld = 1'b0;
    check("unfull_issue_rdy", bus.ld_issue_rdy, 1);
    check("full_no_push15", bus.busy_mask, 32'h0000_7000);
    resp(32'hABCD_0000);
    exp_wr(5'd12, 32'hFFFF_ABCD);
    step();
    resp(32'hCAFE_F00D);
    exp_wr(5'd13, 32'hCAFE_F00D);
    step();
    resp(32'h7FFF_1234);
    exp_wr(5'd14, 32'h0000_7FFF);
    step();
    idle();
    check("full_busy_empty", bus.busy_mask, 0);

    // Load to x0: no write, but the queue pops.
    issue(5'd0, 2'b10, 1'b0, 2'd0);
    step();
    idle();
    check("x0_busy", bus.busy_mask, 0);
    resp(32'h1234_5678);
    step();
    idle();
    check("x0_no_we", bus.rf_we, 0);
    issue(5'd20, 2'b10, 1'b0, 2'd0);
    step();
    idle();
    check("x0_popped_busy20", bus.busy_mask, 32'd1 << 20);
    resp(32'h0BAD_F00D);
    exp_wr(5'd20, 32'h0BAD_F00D);
    step();
    idle();
    // ALU write to x0 is suppressed.
    alu(5'd0, 32'hFFFF_FFFF);
    step();
    idle();
    check("alu_x0_no_we", bus.rf_we, 0);

    // Response with the queue empty.
`ifdef SELEN_WB_ERR_EN
    check("err_before", err, 0);
`endif
    resp(32'h0000_0055);
    step();
    idle();
    check("orphan_no_we", bus.rf_we, 0);
`ifdef SELEN_WB_ERR_EN
    check("err_set", err, 1);
    step();
    check("err_sticky", err, 1);
`endif

    // Same-cycle issue and response on an empty queue: not matched.
    issue(5'd21, 2'b10, 1'b0, 2'd0);
    resp(32'h2121_2121);
    step();
    idle();
    check("same_empty_no_we", bus.rf_we, 0);
    check("same_empty_busy", bus.busy_mask, 32'd1 << 21);
    // Same-cycle issue and response with one outstanding: response pops the older head.
    issue(5'd22, 2'b10, 1'b0, 2'd0);
    resp(32'h0000_0021);
    exp_wr(5'd21, 32'h0000_0021);
    step();
    idle();
    check("same_busy22", bus.busy_mask, 32'd1 << 22);
    resp(32'h0000_0022);
    exp_wr(5'd22, 32'h0000_0022);
    step();
    idle();
    check("same_busy_clr", bus.busy_mask, 0);

    // Reset mid-operation discards outstanding loads.
    issue(5'd25, 2'b10, 1'b0, 2'd0);
    step();
    issue(5'd26, 2'b10, 1'b0, 2'd0);
    step();
    idle();
    check("midrst_busy", bus.busy_mask, (32'd1 << 25) | (32'd1 << 26));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_busy_clr", bus.busy_mask, 0);
    check("midrst_rdy", {bus.ld_issue_rdy, bus.ld_resp_rdy}, 2'b11);
`ifdef SELEN_WB_ERR_EN
    check("midrst_err_clr", err, 0);
`endif
    resp(32'h0000_0099);
    step();
    idle();
    check("midrst_orphan_no_we", bus.rf_we, 0);
`ifdef SELEN_WB_ERR_EN
    check("midrst_err_set", err, 1);
`endif

    repeat (3) step();
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_ctrl.md
# wb_ctrl

Writeback controller for the selen CPU: the single writer of the register file write port (we, adr_wrt, data_in). It merges single-cycle ALU results with out-of-order-in-time, in-order load responses. It extracts and extends load bytes and halfwords from the memory word, and tracks destination registers of outstanding loads as a busy mask for decode hazard stalls.

## Interface
Parameters:
- DEPTH, 4: outstanding-load metadata queue entries (power of two, ≥2)
- XLEN, 32: data width

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- alu_vld  in  1  ALU result valid (always accepted)
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- ld_issue_vld  in  1  load issued to memory
- ld_issue_rd  in  5  load destination
- ld_issue_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- ld_issue_uns  in  1  1 = zero-extend, 0 = sign-extend
- ld_issue_off  in  2  byte address bits [1:0]
- ld_issue_rdy  out  1  queue not full
- ld_resp_vld  in  1  memory read data valid
- ld_resp_data  in  XLEN  raw memory word
- ld_resp_rdy  out  1  response accepted
- rf_we  out  1  register file write enable
- rf_adr  out  5  register file write address
- rf_data  out  XLEN  register file write data
- busy_mask  out  32  bit i set = load to xi outstanding

## Operation
- Issue handshake: entry pushed when ld_issue_vld && ld_issue_rdy. ld_issue_rdy = !full; no push-while-full even if popping the same cycle.
- Responses return in issue order; each pops the queue head.
- Response handshake: accepted when ld_resp_vld && ld_resp_rdy. ld_resp_rdy = !hold_full.
- Alignment, shift = off×8 for byte, off[1]×16 for half:
  - byte: data[shift+7:shift], extended by uns
  - half: data[shift+15:shift], extended by uns; off[0] ignored
  - word: unchanged
- Write priority per cycle: ALU > hold register > direct accepted response.
- Accepted response with ALU also valid: aligned value and rd go to a 1-entry hold register (hold_full=1).
- Destination x0: the queue still pops but rf_we stays 0; ALU writes to x0 are also suppressed.
- busy_mask: OR of one-hot(rd) over valid queue entries plus hold register, bit 0 forced 0. Derived from registered state only; no combinational path from inputs.
- Response with queue empty is a protocol violation: data dropped, no write.

## Timing
- Reset: rf_we=0, rf_adr=0, rf_data=0, busy_mask=0, ld_issue_rdy=1, ld_resp_rdy=1. Queue and hold register cleared.
- Reset mid-operation: all outstanding loads are discarded with no writeback. Responses arriving afterward count as protocol violations.
- rf_we/rf_adr/rf_data are registered:
  - ALU accepted in cycle N: write visible in N+1.
  - Response accepted in N with no ALU: write in N+1.
  - Response collided with ALU in N: write in N+2 at the earliest, later while ALU stays valid. ld_resp_rdy=0 from N+1 until the hold register drains.
- busy_mask bit:
  - sets in the cycle after issue
  - clears in the cycle rf_we is asserted for that load
  - stays set while another queued load targets the same rd
- Issue and response in the same cycle: legal, and the response pops the older head. If the queue is empty, the same-cycle issue is not matched.
- Queue pointers wrap modulo DEPTH; a count of DEPTH+1 states distinguishes full from empty.

## Configuration
- SELEN_WB_ERR_EN defined:
  - adds output err (1 bit, reset 0), a sticky flag set the cycle after a response is accepted with the queue empty
  - cleared only by reset
- SELEN_WB_ERR_EN undefined: no err port, and such responses are silently dropped.

## Structure
- Package selen_wb_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - queue entry struct {rd, size, uns, off}
  - REG_ZERO constant
- Sub-module wb_load_align: combinational, taking {data, size, uns, off} and producing the extended XLEN result. Used by the response path before the hold register/output mux.

## Test plan
- Reset → all outputs at their reset values, busy_mask=0, ld_issue_rdy=1, ld_resp_rdy=1.
- alu_vld, rd=5, data=0xDEADBEEF at N → rf_we=1, rf_adr=5, rf_data=0xDEADBEEF at N+1 only.
- Load byte signed, off=3, rd=7; response 0x80FF1234 → rf_data=0xFFFFFF80. Same with uns=1 → 0x00000080. busy_mask[7] high from the cycle after issue until the writeback cycle.
- Collision: ALU rd=3 and response for load rd=9 at N → rd 3 written at N+1, rd 9 at N+2, ld_resp_rdy=0 at N+1.
- Four issues without responses (DEPTH=4) → ld_issue_rdy=0; one response → ld_issue_rdy=1 next cycle. Half-word off=2 on 0xABCD0000 signed → 0xFFFFABCD.
- Load to x0 → no rf_we and the queue pops. Response with empty queue → no write, and err=1 when SELEN_WB_ERR_EN is defined.
